// File: rtl/output_stage_fifo.sv
`timescale 1ns/1ps
// Generic first-word-fall-through FIFO. A pushed word is at the head one cycle after the push.
// Backpressure: a push is ignored when full and a pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign pop_vld = (count != '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && pop_vld;
    // The head is forced to zero when empty so stale storage never reaches the port.
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// ASP output stage: classifies accepted transactions and queues host and network words.
// Latency 1 cycle to FIFO heads and flags; backpressure: in_ready drops when either FIFO is full.
module output_stage_fifo #(
    parameter int data_size = 32,
    parameter int tag_size  = 8,
    parameter int depth     = 4,
    parameter int max_retry = 3,
    localparam int NW = data_size + tag_size,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           opcode_in,
    input  logic                 soft_error_in,
    input  logic [data_size-1:0] tx_data_in,
    input  logic [NW-1:0]        tx_data_plus_tag_in,
    input  logic                 tag_match_in,
    input  logic [data_size-1:0] rx_data_in,
    input  logic [NW-1:0]        ndt_in,
    output logic                 host_valid_out,
    input  logic                 host_ready_in,
    output logic [data_size-1:0] host_data_out,
    output logic                 net_valid_out,
    input  logic                 net_ready_in,
    output logic [NW-1:0]        ndt_out,
    output logic                 parity_error_out,
    output logic                 network_ack_out,
    output logic                 retry_exhausted_out,
    output logic                 error_drop_out,
    output logic [CW-1:0]        host_count_out,
    output logic [CW-1:0]        net_count_out
);
    logic                 ready_en;
    logic                 host_full;
    logic                 net_full;
    logic                 accept;
    logic                 err;
    logic                 rxa;
    logic                 txe;
    logic                 host_push;
    logic                 net_push;
    logic [data_size-1:0] host_word;
    logic [NW-1:0]        net_word;
    logic [7:0]           err_cnt;
    logic [7:0]           err_cnt_nxt;

    // ready_en keeps in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign in_ready  = ready_en && !host_full && !net_full;
    assign accept    = in_valid && in_ready;
    assign err       = soft_error_in;
    assign rxa       = (opcode_in == 2'b10) && tag_match_in;
    assign txe       = (opcode_in == 2'b01);
    assign host_push = accept && ((err && !retry_exhausted_out) || rxa);
    assign host_word = err ? tx_data_in : rx_data_in;
    assign net_push  = accept && ((txe && !err) || rxa);
    assign net_word  = txe ? tx_data_plus_tag_in : ndt_in;

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (accept) begin
            if (!err)                          err_cnt_nxt = '0;
            else if (err_cnt != 8'(max_retry)) err_cnt_nxt = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt             <= '0;
            retry_exhausted_out <= 1'b0;
            parity_error_out    <= 1'b0;
            network_ack_out     <= 1'b0;
            error_drop_out      <= 1'b0;
        end else begin
            err_cnt             <= err_cnt_nxt;
            retry_exhausted_out <= (err_cnt_nxt == 8'(max_retry));
            if (accept) parity_error_out <= err;
            network_ack_out     <= accept && rxa;
            error_drop_out      <= accept && err && retry_exhausted_out;
        end
    end

    sync_fifo #(.WIDTH(data_size), .DEPTH(depth)) u_host_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (host_push),
        .push_dat (host_word),
        .pop_rdy  (host_ready_in),
        .pop_vld  (host_valid_out),
        .pop_dat  (host_data_out),
        .count    (host_count_out),
        .full     (host_full)
    );

    sync_fifo #(.WIDTH(NW), .DEPTH(depth)) u_net_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (net_push),
        .push_dat (net_word),
        .pop_rdy  (net_ready_in),
        .pop_vld  (net_valid_out),
        .pop_dat  (ndt_out),
        .count    (net_count_out),
        .full     (net_full)
    );
endmodule
